// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared FSM state type and constants for the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  localparam logic [31:0] DIV_ZERO_Q_DEF = 32'hFFFF_FFFF;
  function automatic int cnt_w(input int bpc);
    return $clog2(32 / bpc + 1);
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one combinational step of shift-add multiply or restoring divide
module mdu_iter #(
  parameter int BPC = 1
) (
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);
  localparam int W = 32 + BPC;
  logic [W-1:0] upper;
  logic [32:0]  diff;
  always_comb begin
    upper = W'(acc_i[63:32]) + W'(opnd_i) * W'(acc_i[BPC-1:0]);
    diff  = acc_i[63:31] - {1'b0, opnd_i};
    acc_o = !is_div_i ? {upper, acc_i[31:BPC]}
          : diff[32]  ? {acc_i[62:0], 1'b0}
          :             {diff[31:0], acc_i[30:0], 1'b1};
  end
endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: iterative MIPS32 mult/div unit with HI/LO write pulse and hazard stall
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int          MUL_BPC    = 1,
  parameter logic [31:0] DIV_ZERO_Q = DIV_ZERO_Q_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mult_en_e,
  input  logic        div_en_e,
  input  logic        unsigned_e,
  input  logic [31:0] op_a_e,
  input  logic [31:0] op_b_e,
  input  logic        hilo_use_d,
  input  logic        muldiv_d,
  output logic        busy,
  output logic        stall_hilo,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  // division always takes 32 steps, so it sets the counter width
  localparam int CW = cnt_w(1);
  localparam logic [CW-1:0] MUL_LAST = CW'(32 / MUL_BPC - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(31);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d, iter_acc, prod;
  logic [31:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b;
  logic          mul_q, mul_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, we_q, we_d;
  logic          sa, sb, start, b_zero;

  mdu_iter #(.BPC(MUL_BPC)) u_iter (
    .is_div_i(state_q == DIV),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (iter_acc)
  );

  assign busy       = state_q != IDLE;
  assign start      = mult_en_e | div_en_e;
  assign stall_hilo = (busy | start) & (hilo_use_d | muldiv_d);
  assign hilo_we    = we_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;

  always_comb begin
    sa       = ~unsigned_e & op_a_e[31];
    sb       = ~unsigned_e & op_b_e[31];
    mag_a    = sa ? -op_a_e : op_a_e;
    mag_b    = sb ? -op_b_e : op_b_e;
    b_zero   = op_b_e == '0;
    prod     = neg_lo_q ? -acc_q : acc_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    mul_d    = mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    we_d     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = mult_en_e ? MUL : b_zero ? DONE : DIV;
        cnt_d    = '0;
        mul_d    = mult_en_e;
        opnd_d   = mult_en_e ? mag_a : mag_b;
        // divide-by-zero preloads its final answer and skips iteration
        acc_d    = mult_en_e ? {32'd0, mag_b} : b_zero ? {op_a_e, DIV_ZERO_Q} : {32'd0, mag_a};
        neg_lo_d = (sa ^ sb) & (mult_en_e | ~b_zero);
        neg_hi_d = ~mult_en_e & sa & ~b_zero;
      end
      MUL, DIV: begin
        acc_d   = iter_acc;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == (state_q == MUL ? MUL_LAST : DIV_LAST) ? DONE : state_q;
      end
      DONE: begin
        hi_d    = mul_q ? prod[63:32] : neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
        lo_d    = mul_q ? prod[31:0] : neg_lo_q ? -acc_q[31:0] : acc_q[31:0];
        we_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      mul_q    <= mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      we_q     <= we_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(mult_en_e && div_en_e));
  assert property (@(posedge clk) disable iff (!rst_n) !(busy && start));
endmodule
